// File: rtl/nfa_report_collector.sv
// nfa_report_collector
//   Collects per-cycle report vectors from an automata cluster. It timestamps
//   each non-zero vector with the offset of the symbol that produced it, then
//   buffers the records in a small FIFO. The records are presented on a
//   valid/ready stream. Records lost to back-pressure set a sticky overflow flag.
//
// Ports
//   clk_i          clock, rising edge
//   reset_i        asynchronous active-high reset (shared with the cluster)
//   run_i          symbol-advance strobe (same signal as the cluster's run)
//   flush_i        synchronous clear of offset, FIFO and flags
//   report_vec_i   cluster report outputs (registered inside the STEs)
//   out_valid_o    head record valid
//   out_ready_i    consumer accepts the head record
//   out_mask_o     report bits of the head record
//   out_offset_o   symbol offset of the head record
//   fifo_count_o   current FIFO occupancy
//   overflow_o     sticky: at least one record was dropped
//   drop_count_o   saturating count of dropped records; this port exists only
//                  when NFA_REPORT_DROP_COUNT_EN is defined
//
// Build option
//   NFA_REPORT_DROP_COUNT_EN  adds drop_count_o. When it is undefined, only
//                             overflow_o reports loss.

module nfa_report_collector #(
  parameter int NUM_REPORTS = 4,
  parameter int OFFSET_W    = 32,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          run_i,
  input  logic                          flush_i,
  input  logic [NUM_REPORTS-1:0]        report_vec_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [NUM_REPORTS-1:0]        out_mask_o,
  output logic [OFFSET_W-1:0]           out_offset_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
`ifdef NFA_REPORT_DROP_COUNT_EN
  output logic [15:0]                   drop_count_o,
`endif
  output logic                          overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic [OFFSET_W-1:0]    offset_q, offset_d;
  logic                   run_dly_q, run_dly_d;
  logic [OFFSET_W-1:0]    offset_dly_q, offset_dly_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic                   overflow_q, overflow_d;
  logic [PW-1:0]          count;
  logic                   push, pop, full, wr_en, drop;

  logic [NUM_REPORTS-1:0] mask_mem_q [FIFO_DEPTH];
  logic [OFFSET_W-1:0]    off_mem_q  [FIFO_DEPTH];

  // The STE outputs lag the symbol by one cycle. A report seen now therefore
  // belongs to the symbol that was consumed on the previous run cycle.
  assign push  = run_dly_q && (|report_vec_i);
  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == PW'(FIFO_DEPTH));
  assign pop   = out_valid_o && out_ready_i;
  // When the FIFO is full, a push can still be accepted if a pop frees the
  // head slot on the same edge.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_comb begin
    offset_d     = offset_q;
    run_dly_d    = run_i;
    offset_dly_d = offset_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    overflow_d   = overflow_q;
    if (flush_i) begin
      offset_d     = '0;
      run_dly_d    = 1'b0;
      offset_dly_d = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      overflow_d   = 1'b0;
    end else begin
      if (run_i) offset_d = offset_q + 1'b1;
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      if (drop)  overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      offset_q     <= '0;
      run_dly_q    <= 1'b0;
      offset_dly_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
    end else begin
      offset_q     <= offset_d;
      run_dly_q    <= run_dly_d;
      offset_dly_q <= offset_dly_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
    end
  end

  // The storage needs no reset because the outputs are masked while the
  // FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (wr_en && !flush_i) begin
      mask_mem_q[wr_ptr_q[AW-1:0]] <= report_vec_i;
      off_mem_q[wr_ptr_q[AW-1:0]]  <= offset_dly_q;
    end
  end

`ifdef NFA_REPORT_DROP_COUNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (flush_i)                            drop_cnt_d = '0;
    else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) drop_cnt_q <= '0;
    else         drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count_o = drop_cnt_q;
`endif

  assign out_valid_o  = (count != '0);
  assign out_mask_o   = out_valid_o ? mask_mem_q[rd_ptr_q[AW-1:0]] : '0;
  assign out_offset_o = out_valid_o ? off_mem_q[rd_ptr_q[AW-1:0]]  : '0;
  assign fifo_count_o = count;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_nfa_report_collector.sv
module tb_nfa_report_collector;
  localparam int NR = 4;
  localparam int OW = 32;
  localparam int FD = 8;
  localparam int CW = $clog2(FD) + 1;

  logic clk = 1'b0;
  logic reset, run, flush, out_ready;
  logic [NR-1:0] report_vec;

  logic          out_valid, overflow;
  logic [NR-1:0] out_mask;
  logic [OW-1:0] out_offset;
  logic [CW-1:0] fifo_count;

  logic          n_valid, n_overflow;
  logic [NR-1:0] n_mask;
  logic [3:0]    n_offset;
  logic [CW-1:0] n_count;
`ifdef NFA_REPORT_DROP_COUNT_EN
  logic [15:0]   drop_count, n_drop_count;
`endif

  nfa_report_collector #(.NUM_REPORTS(NR), .OFFSET_W(OW), .FIFO_DEPTH(FD)) dut (
    .clk_i(clk), .reset_i(reset), .run_i(run), .flush_i(flush),
    .report_vec_i(report_vec), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_mask_o(out_mask), .out_offset_o(out_offset), .fifo_count_o(fifo_count),
`ifdef NFA_REPORT_DROP_COUNT_EN
    .drop_count_o(drop_count),
`endif
    .overflow_o(overflow));

  // Narrow-offset copy that sees the same stimulus, used for the wrap check.
  nfa_report_collector #(.NUM_REPORTS(NR), .OFFSET_W(4), .FIFO_DEPTH(FD)) dut_w4 (
    .clk_i(clk), .reset_i(reset), .run_i(run), .flush_i(flush),
    .report_vec_i(report_vec), .out_valid_o(n_valid), .out_ready_i(out_ready),
    .out_mask_o(n_mask), .out_offset_o(n_offset), .fifo_count_o(n_count),
`ifdef NFA_REPORT_DROP_COUNT_EN
    .drop_count_o(n_drop_count),
`endif
    .overflow_o(n_overflow));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NR-1:0] mask;
    logic [OW-1:0] off;
  } rec_t;

  typedef struct {
    logic          run;
    logic [NR-1:0] rv;
    logic          rdy;
    logic          fl;
    logic          ev;
    logic [NR-1:0] em;
    logic [OW-1:0] eo;
    int            ec;
    logic          eovf;
  } vec_t;

  rec_t sbq[$];
  int   nvec = 0;
  int   nerr = 0;

  logic [OW-1:0] m_off, m_off_d;
  logic          m_run_d, m_ovf;
`ifdef NFA_REPORT_DROP_COUNT_EN
  int            m_drops;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    sbq.delete();
    m_off = '0; m_off_d = '0; m_run_d = 1'b0; m_ovf = 1'b0;
`ifdef NFA_REPORT_DROP_COUNT_EN
    m_drops = 0;
`endif
  endtask

  // One clock cycle: drive at negedge, check/pop the head, clock, update model, check state.
  task automatic step(input logic r, input logic [NR-1:0] rv, input logic rdy, input logic fl);
    rec_t h;
    @(negedge clk);
    run = r; report_vec = rv; out_ready = rdy; flush = fl;
    #1;
    check("valid_vs_model", out_valid, sbq.size() != 0);
    if (out_valid && rdy && !fl) begin
      if (sbq.size() == 0) check("pop_with_empty_model", out_valid, 1'b0);
      else begin
        h = sbq.pop_front();
        check("pop_mask", out_mask, h.mask);
        check("pop_offset", out_offset, h.off);
      end
    end
    @(posedge clk);
    if (fl) model_clear();
    else begin
      if (m_run_d && rv != '0) begin
        if (sbq.size() < FD) sbq.push_back({rv, m_off_d});
        else begin
          m_ovf = 1'b1;
`ifdef NFA_REPORT_DROP_COUNT_EN
          if (m_drops < 65535) m_drops++;
`endif
        end
      end
      m_run_d = r;
      m_off_d = m_off;
      if (r) m_off = m_off + 1;
    end
    #1;
    check("count_vs_model", fifo_count, sbq.size());
    check("overflow_vs_model", overflow, m_ovf);
`ifdef NFA_REPORT_DROP_COUNT_EN
    check("drops_vs_model", drop_count, m_drops);
`endif
  endtask

  vec_t tbl[13];

  initial begin
    // Single report at offset 2, then a multi-report at offset 7 held under back-pressure.
    tbl[0]  = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 0, 0, 1'b0};
    tbl[1]  = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 0, 0, 1'b0};
    tbl[2]  = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 0, 0, 1'b0};
    tbl[3]  = '{1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 4'h1, 2, 1, 1'b0};
    tbl[4]  = '{1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 0, 0, 1'b0};
    tbl[5]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 0, 0, 1'b0};
    tbl[6]  = '{1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0, 0, 0, 1'b0};
    tbl[7]  = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 0, 0, 1'b0};
    tbl[8]  = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 0, 0, 1'b0};
    tbl[9]  = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 0, 0, 1'b0};
    tbl[10] = '{1'b0, 4'hA, 1'b0, 1'b0, 1'b1, 4'hA, 7, 1, 1'b0};
    tbl[11] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'hA, 7, 1, 1'b0};
    tbl[12] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 0, 0, 1'b0};

    reset = 1'b1; run = 1'b0; flush = 1'b0; out_ready = 1'b0; report_vec = '0;
    model_clear();
    #2;
    check("rst_valid", out_valid, 1'b0);
    check("rst_mask", out_mask, 4'h0);
    check("rst_offset", out_offset, 32'h0);
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow, 1'b0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].run, tbl[i].rv, tbl[i].rdy, tbl[i].fl);
      check($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        check($sformatf("tbl%0d_mask", i), out_mask, tbl[i].em);
        check($sformatf("tbl%0d_offset", i), out_offset, tbl[i].eo);
      end
      check($sformatf("tbl%0d_count", i), fifo_count, tbl[i].ec);
      check($sformatf("tbl%0d_overflow", i), overflow, tbl[i].eovf);
    end

    // Back-pressure: nine qualifying cycles into an eight-deep FIFO.
    step(1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b1, 4'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) step(1'b1, 4'h1, 1'b0, 1'b0);
    step(1'b0, 4'h1, 1'b0, 1'b0);
    check("ovf_count", fifo_count, 8);
    check("ovf_flag", overflow, 1'b1);
`ifdef NFA_REPORT_DROP_COUNT_EN
    check("ovf_drop_count", drop_count, 16'd1);
`endif
    check("ovf_head_offset", out_offset, 32'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 4'h0, 1'b1, 1'b0);

    // Flush with three queued entries and a coincident push and pop.
    step(1'b1, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 4'h2, 1'b0, 1'b0);
    check("preflush_count", fifo_count, 3);
    step(1'b0, 4'h4, 1'b1, 1'b1);
    check("flush_valid", out_valid, 1'b0);
    check("flush_count", fifo_count, 0);
    check("flush_overflow", overflow, 1'b0);
    step(1'b1, 4'h0, 1'b0, 1'b0);
    step(1'b0, 4'h8, 1'b0, 1'b0);
    check("postflush_offset", out_offset, 32'd0);
    check("postflush_mask", out_mask, 4'h8);
    step(1'b0, 4'h0, 1'b1, 1'b0);

    // Full FIFO: a push and a pop on the same edge.
    step(1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b1, 4'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) step(1'b1, 4'h1, 1'b0, 1'b0);
    check("full_count", fifo_count, 8);
    step(1'b0, 4'h2, 1'b1, 1'b0);
    check("fullpp_count", fifo_count, 8);
    check("fullpp_overflow", overflow, 1'b0);
    check("fullpp_head_offset", out_offset, 32'd1);
    for (int i = 0; i < 8; i++) step(1'b0, 4'h0, 1'b1, 1'b0);

    // Offset wrap on the 4-bit copy: the 17th symbol has offset 16, which wraps to 0.
    step(1'b0, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) step(1'b1, 4'h0, 1'b0, 1'b0);
    step(1'b0, 4'h1, 1'b0, 1'b0);
    check("wrap_valid", n_valid, 1'b1);
    check("wrap_offset", n_offset, 4'd0);
    check("wrap_count", n_count, 1);
    check("wrap_overflow", n_overflow, 1'b0);
    check("wide_offset", out_offset, 32'd16);
    step(1'b0, 4'h0, 1'b1, 1'b0);

    // Random traffic checked against the scoreboard.
    for (int i = 0; i < 150; i++)
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
           1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 49) == 0));

    // Asynchronous reset between edges while entries are queued.
    step(1'b0, 4'h0, 1'b0, 1'b1);
    step(1'b1, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 4'h3, 1'b0, 1'b0);
    check("prereset_overflow", overflow, 1'b1);
    @(negedge clk);
    run = 1'b0; report_vec = '0; out_ready = 1'b0; flush = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 1'b0);
    check("async_rst_count", fifo_count, 0);
    check("async_rst_overflow", overflow, 1'b0);
    check("async_rst_mask", out_mask, 4'h0);
`ifdef NFA_REPORT_DROP_COUNT_EN
    check("async_rst_drops", drop_count, 16'd0);
`endif
    model_clear();
    @(negedge clk); reset = 1'b0;
    step(1'b1, 4'h0, 1'b0, 1'b0);
    step(1'b0, 4'h5, 1'b0, 1'b0);
    check("postrst_offset", out_offset, 32'd0);
    step(1'b0, 4'h0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
